// File: rtl/lcd_pkg.sv
// ============================================================================
// Module  : lcd_pkg
// Brief   : Shared types, default 50 MHz timing and command helpers for the
//           4-bit character LCD path.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DELAY = 3'd5
    } lcd_state_e;

    localparam int unsigned LCD_SETUP_CYC      = 2;
    localparam int unsigned LCD_PULSE_CYC      = 12;
    localparam int unsigned LCD_HOLD_CYC       = 1;
    localparam int unsigned LCD_GAP_CYC        = 50;
    localparam int unsigned LCD_CMD_DELAY_CYC  = 2000;
    localparam int unsigned LCD_LONG_DELAY_CYC = 82000;

    // Clear display (0x01) and return home (0x02/0x03) need the long settle time.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (!rs) && (data[7:2] == 6'd0) && (data != 8'd0);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_delay_counter.sv
// ============================================================================
// Module  : lcd_delay_counter
// Brief   : Loadable down-counter that stops at zero and flags it.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module lcd_delay_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/lcd_nibble_writer.sv
// ============================================================================
// Module  : lcd_nibble_writer
// Brief   : Handshaked byte/nibble write engine driving a 4-bit character LCD.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC      = LCD_SETUP_CYC,
    parameter int unsigned PULSE_CYC      = LCD_PULSE_CYC,
    parameter int unsigned HOLD_CYC       = LCD_HOLD_CYC,
    parameter int unsigned GAP_CYC        = LCD_GAP_CYC,
    parameter int unsigned CMD_DELAY_CYC  = LCD_CMD_DELAY_CYC,
    parameter int unsigned LONG_DELAY_CYC = LCD_LONG_DELAY_CYC
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic       in_rs_i,
    input  logic [7:0] in_data_i,
    input  logic       in_nibble_only_i,
    output logic       cmd_done_o,
    output logic       lcd_rs_o,
    output logic       lcd_e_o,
    output logic       lcd_w_o,
    output logic [3:0] lcd_data_o
);

    localparam int unsigned MAX_CYC = max_u(max_u(max_u(SETUP_CYC, PULSE_CYC),
                                                  max_u(HOLD_CYC, GAP_CYC)),
                                            max_u(CMD_DELAY_CYC, LONG_DELAY_CYC));
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] C_SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] C_PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] C_HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] C_GAP_LD   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] C_CMD_LD   = CNT_W'(CMD_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] C_LONG_LD  = CNT_W'(LONG_DELAY_CYC - 1);

    if (SETUP_CYC == 0 || PULSE_CYC == 0 || HOLD_CYC == 0 || GAP_CYC == 0 ||
        CMD_DELAY_CYC == 0 || LONG_DELAY_CYC == 0) begin : g_bad_timing
        $error("lcd_nibble_writer: every timing parameter must be at least 1");
    end

    lcd_state_e       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             cmd_done_q, cmd_done_d;
    logic             lcd_e_q, lcd_e_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic [3:0]       lcd_data_q, lcd_data_d;
    logic [3:0]       low_nib_q;
    logic             nib_only_q;
    logic             long_q;
    logic             second_q;

    logic             accept;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;
    logic [CNT_W-1:0] delay_ld;

    assign accept   = in_valid_i && in_ready_q;
    assign delay_ld = long_q ? C_LONG_LD : C_CMD_LD;

    lcd_delay_counter #(
        .WIDTH (CNT_W)
    ) u_delay_counter (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .count_o    (cnt_val),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            cmd_done_q <= 1'b0;
            lcd_e_q    <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= 4'd0;
            low_nib_q  <= 4'd0;
            nib_only_q <= 1'b0;
            long_q     <= 1'b0;
            second_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            cmd_done_q <= cmd_done_d;
            lcd_e_q    <= lcd_e_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_data_q <= lcd_data_d;
            if (accept) begin
                low_nib_q  <= in_data_i[3:0];
                nib_only_q <= in_nibble_only_i;
                long_q     <= !in_nibble_only_i && is_long_cmd(in_rs_i, in_data_i);
                second_q   <= 1'b0;
            end else if (state_q == ST_GAP && cnt_zero) begin
                second_q   <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d      = ST_SETUP;
                    cnt_load     = 1'b1;
                    cnt_load_val = C_SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_d      = ST_PULSE;
                    cnt_load     = 1'b1;
                    cnt_load_val = C_PULSE_LD;
                end
            end
            ST_PULSE: begin
                if (cnt_zero) begin
                    state_d      = ST_HOLD;
                    cnt_load     = 1'b1;
                    cnt_load_val = C_HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    if (!second_q && !nib_only_q) begin
                        state_d      = ST_GAP;
                        cnt_load_val = C_GAP_LD;
                    end else begin
                        state_d      = ST_DELAY;
                        cnt_load_val = delay_ld;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_zero) begin
                    state_d      = ST_SETUP;
                    cnt_load     = 1'b1;
                    cnt_load_val = C_SETUP_LD;
                end
            end
            ST_DELAY: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so the registered pins line up
    // with the state they belong to; cmd_done marks the final DELAY cycle.
    always_comb begin
        in_ready_d = (state_d == ST_IDLE);
        lcd_e_d    = (state_d == ST_PULSE);
        cmd_done_d = (state_d == ST_DELAY) &&
                     (cnt_load ? (cnt_load_val == '0) : (cnt_val == CNT_W'(1)));
        lcd_rs_d   = lcd_rs_q;
        lcd_data_d = lcd_data_q;
        if (accept) begin
            lcd_rs_d   = in_rs_i;
            lcd_data_d = in_data_i[7:4];
        end else if (state_q == ST_GAP && cnt_zero) begin
            lcd_data_d = low_nib_q;
        end
    end

    assign in_ready_o = in_ready_q;
    assign cmd_done_o = cmd_done_q;
    assign lcd_e_o    = lcd_e_q;
    assign lcd_rs_o   = lcd_rs_q;
    assign lcd_data_o = lcd_data_q;
    assign lcd_w_o    = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_lcd_nibble_writer.sv
// ============================================================================
// Module  : tb_lcd_nibble_writer
// Brief   : Directed, table-driven self-checking bench for lcd_nibble_writer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_lcd_nibble_writer;

    localparam int TB_S = 2;
    localparam int TB_P = 3;
    localparam int TB_H = 1;
    localparam int TB_G = 4;
    localparam int TB_D = 10;
    localparam int TB_L = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_rs = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_nib = 1'b0;
    logic       cmd_done;
    logic       lcd_rs;
    logic       lcd_e;
    logic       lcd_w;
    logic [3:0] lcd_data;

    int n_total = 0;
    int n_pass  = 0;

    lcd_nibble_writer #(
        .SETUP_CYC      (TB_S),
        .PULSE_CYC      (TB_P),
        .HOLD_CYC       (TB_H),
        .GAP_CYC        (TB_G),
        .CMD_DELAY_CYC  (TB_D),
        .LONG_DELAY_CYC (TB_L)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .in_rs_i          (in_rs),
        .in_data_i        (in_data),
        .in_nibble_only_i (in_nib),
        .cmd_done_o       (cmd_done),
        .lcd_rs_o         (lcd_rs),
        .lcd_e_o          (lcd_e),
        .lcd_w_o          (lcd_w),
        .lcd_data_o       (lcd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Pin-level timing watcher: setup/hold around every E pulse, lcd_w stuck low.
    logic [4:0] mon_prev_bus = 5'd0;
    logic       mon_prev_e   = 1'b0;
    int         mon_stable   = 0;
    always @(negedge clk) begin
        if (reset) begin
            mon_prev_bus = 5'd0;
            mon_prev_e   = 1'b0;
            mon_stable   = 0;
        end else begin
            check("lcd_w_low", lcd_w, 0);
            mon_stable = ({lcd_rs, lcd_data} == mon_prev_bus) ? mon_stable + 1 : 1;
            if (lcd_e && !mon_prev_e)
                check("setup_stable", int'(mon_stable >= TB_S + 1), 1);
            if (!lcd_e && mon_prev_e)
                check("hold_stable", int'({lcd_rs, lcd_data} == mon_prev_bus), 1);
            mon_prev_bus = {lcd_rs, lcd_data};
            mon_prev_e   = lcd_e;
        end
    end

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic       nib;
        int         busy;
        int         pulses;
        logic [3:0] hi;
        logic [3:0] lo;
    } vec_t;

    vec_t vecs[8];

    task automatic wait_ready();
        for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
        check("ready_wait", in_ready, 1);
    endtask

    task automatic send(input vec_t v);
        int         busy = 0, pulses = 0, ehigh = 0, dones = 0, done_at = -1, first_rise = -1;
        logic       prev_e = 1'b0;
        logic [3:0] nibs[2];
        nibs[0] = 4'hx;
        nibs[1] = 4'hx;
        wait_ready();
        in_valid = 1'b1;
        in_rs    = v.rs;
        in_data  = v.data;
        in_nib   = v.nib;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_rs    = ~v.rs;
        in_data  = 8'($urandom);
        in_nib   = ~v.nib;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) break;
            busy++;
            if (lcd_e && !prev_e) begin
                if (pulses < 2) nibs[pulses] = lcd_data;
                if (pulses == 0) first_rise = busy;
                check("rs_at_pulse", lcd_rs, v.rs);
                pulses++;
                ehigh = 0;
            end
            if (lcd_e) ehigh++;
            if (!lcd_e && prev_e) check("pulse_width", ehigh, TB_P);
            if (cmd_done) begin
                dones++;
                done_at = busy;
            end
            prev_e = lcd_e;
        end
        check("busy_len", busy, v.busy);
        check("pulse_count", pulses, v.pulses);
        check("first_e_latency", first_rise, TB_S + 1);
        check("hi_nibble", nibs[0], v.hi);
        if (v.pulses == 2) check("lo_nibble", nibs[1], v.lo);
        check("cmd_done_count", dones, 1);
        check("cmd_done_last", done_at, busy);
        check("idle_rs_hold", lcd_rs, v.rs);
        check("idle_data_hold", lcd_data, (v.pulses == 2) ? v.lo : v.hi);
        check("idle_no_e", lcd_e, 0);
    endtask

    task automatic run_b2b();
        logic [7:0] bytes[3];
        logic [3:0] exp_nib[6];
        int         idx = 0, nib = 0, dones = 0;
        logic       prev_ready = 1'b0, prev_e = 1'b0, finished = 1'b0;
        bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
        for (int k = 0; k < 3; k++) begin
            exp_nib[2*k]   = bytes[k][7:4];
            exp_nib[2*k+1] = bytes[k][3:0];
        end
        wait_ready();
        in_rs    = 1'b1;
        in_nib   = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 300 && !finished; c++) begin
            if (c > 0) @(negedge clk);
            if (in_ready) begin
                check("b2b_no_bubble", prev_ready, 0);
                if (idx == 3) begin
                    in_valid = 1'b0;
                    finished = 1'b1;
                end else begin
                    in_data = bytes[idx];
                    idx++;
                end
            end else begin
                in_data = 8'($urandom);
                if (lcd_e && !prev_e) begin
                    if (nib < 6) check("b2b_nibble", lcd_data, exp_nib[nib]);
                    nib++;
                end
            end
            if (cmd_done) dones++;
            prev_ready = in_ready;
            prev_e     = lcd_e;
        end
        check("b2b_complete", finished, 1);
        check("b2b_nibble_count", nib, 6);
        check("b2b_done_count", dones, 3);
    endtask

    task automatic run_reset_mid_pulse();
        int seen = 0;
        wait_ready();
        in_valid = 1'b1;
        in_rs    = 1'b1;
        in_data  = 8'h5A;
        in_nib   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 0; c < 50 && !lcd_e; c++) @(negedge clk);
        check("reset_reach_pulse", lcd_e, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_e", lcd_e, 0);
        check("async_rs", lcd_rs, 0);
        check("async_data", lcd_data, 0);
        check("async_ready", in_ready, 0);
        check("async_done", cmd_done, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst2", in_ready, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (lcd_e) seen++;
        end
        check("no_resume", seen, 0);
        send(vecs[0]);
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'h48, 1'b0, 26, 2, 4'h4, 4'h8};
        vecs[1] = '{1'b0, 8'h01, 1'b0, 36, 2, 4'h0, 4'h1};
        vecs[2] = '{1'b0, 8'h28, 1'b0, 26, 2, 4'h2, 4'h8};
        vecs[3] = '{1'b1, 8'h01, 1'b0, 26, 2, 4'h0, 4'h1};
        vecs[4] = '{1'b0, 8'h30, 1'b1, 16, 1, 4'h3, 4'h0};
        vecs[5] = '{1'b0, 8'h02, 1'b0, 36, 2, 4'h0, 4'h2};
        vecs[6] = '{1'b0, 8'h03, 1'b1, 16, 1, 4'h0, 4'h0};
        vecs[7] = '{1'b0, 8'h04, 1'b0, 26, 2, 4'h0, 4'h4};

        repeat (2) @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_e", lcd_e, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_data", lcd_data, 0);
        check("rst_done", cmd_done, 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);

        for (int i = 0; i < 8; i++) send(vecs[i]);
        run_b2b();
        run_reset_mid_pulse();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lcd_nibble_writer.md
# lcd_nibble_writer

Parametrised sequential write engine for a character LCD on a 4-bit bus. It accepts one command or data byte per valid/ready handshake, splits it into high then low nibble, and drives RS, E and data with programmable setup, pulse, hold, inter-nibble and post-command delays. It sits between the LCD init/refresh controller and the LCD pins and replaces the externally phased, purely combinational pin driver. A nibble-only mode covers the power-on init sequence.

## Interface
- SETUP_CYC, 2: cycles RS/data are stable before E rises (≥1)
- PULSE_CYC, 12: cycles E is high (≥1)
- HOLD_CYC, 1: cycles RS/data are held after E falls (≥1)
- GAP_CYC, 50: idle cycles between high and low nibble (≥1)
- CMD_DELAY_CYC, 2000: post-command wait for normal commands and data (≥1)
- LONG_DELAY_CYC, 82000: post-command wait for clear/home (≥1)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  engine idle; request accepted when in_valid && in_ready at rising clk
- in_rs  in  1  0 = command, 1 = data
- in_data  in  8  byte to write
- in_nibble_only  in  1  send in_data[7:4] only
- cmd_done  out  1  one-cycle pulse when the post-command delay ends
- lcd_rs  out  1  register select
- lcd_e  out  1  enable strobe
- lcd_w  out  1  read/write, constant 0 (write only)
- lcd_data  out  4  nibble bus

## Operation
- States: IDLE, SETUP, PULSE, HOLD, GAP, DELAY. One down-counter of width $clog2(max parameter + 1), loaded on each state entry with the state's length minus 1; state exits when the counter reaches 0.
- IDLE: in_ready=1, lcd_e=0. On accept: capture in_rs, in_data, in_nibble_only, long flag; load lcd_rs=in_rs, lcd_data=in_data[7:4]; go SETUP.
- SETUP (SETUP_CYC) -> PULSE (PULSE_CYC, lcd_e=1) -> HOLD (HOLD_CYC).
- HOLD exit: high nibble and not nibble_only -> GAP; else -> DELAY.
- GAP (GAP_CYC, lcd_e=0) exit: lcd_data=captured low nibble; -> SETUP.
- DELAY: length LONG_DELAY_CYC if long flag, else CMD_DELAY_CYC; exit -> IDLE, cmd_done=1 for that cycle.
- Long flag = (in_rs==0) && (in_data[7:2]==0) && (in_data!=0), i.e. 0x01 clear, 0x02/0x03 home. Nibble-only writes always use CMD_DELAY_CYC.
- lcd_rs and lcd_data change only on accept and on GAP exit; hold their values otherwise, including through IDLE.
- in_rs/in_data/in_nibble_only ignored while in_ready=0.
- Reset: state IDLE; lcd_e=0, lcd_rs=0, lcd_data=0, cmd_done=0, in_ready=0; lcd_w=0 always. Mid-transfer reset drops lcd_e immediately (async); the partial write is abandoned, not resumed.

## Timing
- All outputs registered; in_ready rises on the first clk edge after reset release.
- Accept at edge N: lcd_rs/lcd_data valid and in_ready=0 from N; lcd_e rises at N+SETUP_CYC.
- E high for exactly PULSE_CYC cycles per nibble; data/RS stable from SETUP_CYC before to HOLD_CYC after every E pulse.
- Busy length (accept to in_ready=1 again): full byte 2·(S+P+H)+G+D; nibble-only S+P+H+D; D selected as above. cmd_done asserts in the last busy cycle.
- Back-to-back: in_valid held high is accepted on the first cycle in_ready=1; no extra bubble.

## Structure
- Shared package lcd_pkg: state enum, default 50 MHz timing constants, is_long_cmd function (used here and by the init controller).
- One sub-module: lcd_delay_counter (load value, count down, zero flag, parametrised width).
- Elaboration check rejects any timing parameter of 0.

## Test plan
Params S=2, P=3, H=1, G=4, D=10, L=20.
- Reset release, then rs=1 data 0x48 -> lcd_data 0x4 then 0x8, two E pulses of 3 cycles, lcd_rs=1 throughout, in_ready low 26 cycles, one cmd_done.
- rs=0 data 0x01 -> long delay, busy 36 cycles; rs=0 data 0x28 -> busy 26; rs=1 data 0x01 -> busy 26.
- nibble_only with data 0x30 -> one E pulse, lcd_data 0x3, busy 16, cmd_done once.
- in_valid held high with three bytes queued by the bench -> accepts on first in_ready cycle each time, in_data changes while busy do not alter lcd_data.
- Assert reset during PULSE -> lcd_e, lcd_rs, lcd_data go 0 without a clock edge; after release next byte transfers cleanly with full timing.
- Checker on every E pulse: data/RS stable ≥2 cycles before rise and ≥1 after fall; lcd_w never 1.
